// File: rtl/uart_pkg.sv
// Shared UART definitions used by the byte transmitter and the future receiver.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts clock cycles inside one UART bit and flags the
// last cycle of the bit with tick. clr holds the count at zero so every frame
// starts on a fresh bit boundary.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count cycles within a bit, wrapping to zero after the last one
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: takes one byte per frame from a valid/ready source
// and serializes it LSB first as start, 8 data bits, optional parity, stop.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit(s).
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] di,
  input  logic                      diValid,
  output logic                      diReady,
  output logic                      txd,
  output logic                      busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic STOP_LAST  = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_byte_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t state, state_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic       stopcnt, stopcnt_n;
  logic       txd_n;
  logic       tick;
  logic       accept;

  assign accept  = diValid && (state == IDLE);
  assign diReady = (state == IDLE);
  assign busy    = (state != IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .tick(tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity;

  // Even parity is taken from the byte as accepted, not from the shifting copy
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^di;
    end
  end
`endif

  // Frame sequencing, shifting and the line level for the coming cycle
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    stopcnt_n = stopcnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = START;
          shreg_n   = di;
          bitcnt_n  = 3'd0;
          stopcnt_n = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n  = {1'b0, shreg[UART_DATA_BITS-1:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (stopcnt == STOP_LAST) begin
            state_n   = IDLE;
            stopcnt_n = 1'b0;
          end else begin
            stopcnt_n = stopcnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    txd_n = UART_IDLE_LEVEL;
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_n = parity;
`endif
      default: txd_n = UART_IDLE_LEVEL;
    endcase
  end

  // State, datapath and the registered line output
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= 3'd0;
      stopcnt <= 1'b0;
      txd     <= UART_IDLE_LEVEL;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bitcnt  <= bitcnt_n;
      stopcnt <= stopcnt_n;
      txd     <= txd_n;
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at 4 clocks per bit, with a second
// instance using two stop bits.
module tb_uart_byte_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 1 + 8 + PAR + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] di = 8'h00;
  logic       diValid = 1'b0;
  logic       diReady, txd, busy;
  logic [7:0] di2 = 8'h00;
  logic       diValid2 = 1'b0;
  logic       diReady2, txd2, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc1[$];
  int acc2[$];

  uart_byte_tx #(.CLK_HZ(16), .BAUD(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .di(di), .diValid(diValid),
    .diReady(diReady), .txd(txd), .busy(busy)
  );

  uart_byte_tx #(.CLK_HZ(16), .BAUD(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .di(di2), .diValid(diValid2),
    .diReady(diReady2), .txd(txd2), .busy(busy2)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Log the cycle number of every accepted byte on both instances
  always @(posedge clk) begin
    if (!rst && diValid && diReady) acc1.push_back(cyc);
    if (!rst && diValid2 && diReady2) acc2.push_back(cyc);
    cyc = cyc + 1;
  end

  // Hard stop in case something never terminates
  initial begin
    #100000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic v);
    di      = b;
    diValid = v;
  endtask

  function automatic logic expBit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Called at the negedge of the first START cycle; returns at the negedge of
  // the IDLE cycle that follows the frame.
  task automatic captureFrame(input logic [7:0] d, input string tag);
    int lowCnt;
    int busyCnt;
    logic [3:0] s;
    lowCnt  = 0;
    busyCnt = 0;
    for (int b = 0; b < NBITS; b++) begin
      s = 4'h0;
      for (int c = 0; c < CPB; c++) begin
        s = {txd, s[3:1]};
        if (!diReady) lowCnt++;
        if (busy) busyCnt++;
        @(negedge clk);
      end
      checkOutput($sformatf("%s_bit%0d", tag, b), {28'd0, s}, {28'd0, {4{expBit(d, b)}}});
    end
    checkOutput({tag, "_readyLowCycles"}, lowCnt, NBITS * CPB);
    checkOutput({tag, "_busyCycles"}, busyCnt, NBITS * CPB);
    checkOutput({tag, "_readyAfter"}, 32'(diReady), 32'd1);
  endtask

  initial begin
    int stable;
    int run;

    // Reset held for three cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_txd", 32'(txd), 32'd1);
    checkOutput("rst_ready", 32'(diReady), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_txd2", 32'(txd2), 32'd1);
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd && diReady && !busy) stable++;
      @(negedge clk);
    end
    checkOutput("idle_stable", stable, 50);

    // Single byte with a one-cycle valid pulse
    applyStimulus(8'h55, 1'b1);
    @(negedge clk);
    applyStimulus(8'h55, 1'b0);
    checkOutput("single_accepted", acc1.size(), 1);
    captureFrame(8'h55, "single");

    // Back-to-back bytes from a two-entry FIFO, valid held
    applyStimulus(8'h00, 1'b1);
    @(negedge clk);
    applyStimulus(8'hFF, 1'b1);
    captureFrame(8'h00, "b2b0");
    @(negedge clk);
    applyStimulus(8'hFF, 1'b0);
    captureFrame(8'hFF, "b2b1");
    checkOutput("b2b_accepts", acc1.size(), 3);
    checkOutput("b2b_gap", acc1[2] - acc1[1], NBITS * CPB + 1);

    // Input changes during the frame must not disturb it
    applyStimulus(8'hA3, 1'b1);
    @(negedge clk);
    applyStimulus(8'h00, 1'b1);
    captureFrame(8'hA3, "stable");
    checkOutput("stable_noMidAccept", acc1.size(), 4);
    applyStimulus(8'h00, 1'b0);
    repeat (3) @(negedge clk);

    // Reset during data bit 3
    applyStimulus(8'hC5, 1'b1);
    @(negedge clk);
    applyStimulus(8'hC5, 1'b0);
    repeat (17) @(negedge clk);
    checkOutput("midrst_bit3", 32'(txd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_txd", 32'(txd), 32'd1);
    checkOutput("midrst_ready", 32'(diReady), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_noRetx", 32'(txd), 32'd1);
    applyStimulus(8'h3C, 1'b1);
    @(negedge clk);
    applyStimulus(8'h3C, 1'b0);
    captureFrame(8'h3C, "afterRst");

    // Parity patterns (plain data frames when parity is not built in)
    applyStimulus(8'h07, 1'b1);
    @(negedge clk);
    applyStimulus(8'h07, 1'b0);
    captureFrame(8'h07, "par07");
    applyStimulus(8'h03, 1'b1);
    @(negedge clk);
    applyStimulus(8'h03, 1'b0);
    captureFrame(8'h03, "par03");

    // Two stop bits: line high for the whole stop period, longer frame
    di2      = 8'h03;
    diValid2 = 1'b1;
    @(negedge clk);
    run = 0;
    for (int i = 0; i < 200 && acc2.size() < 2; i++) begin
      if (busy2) run = txd2 ? run + 1 : 0;
      @(negedge clk);
    end
    diValid2 = 1'b0;
    checkOutput("stop2_accepts", acc2.size(), 2);
    checkOutput("stop2_highRun", run, 2 * CPB);
    if (acc2.size() >= 2)
      checkOutput("stop2_gap", acc2[1] - acc2[0], (1 + 8 + PAR + 2) * CPB + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
